// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// master = the sequencer; slave = the datapath that consumes its enables.
interface multicycle_control_fsm_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         part_of_inst;
    logic               mem_ready;

    logic               PC_write_not_cond;
    logic               PC_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               IR_write;
    logic               reg_write;
    logic [1:0]         mem_to_reg;
    logic               PC_source;
    logic [1:0]         ALU_op;
    logic               ALU_src_a;
    logic [1:0]         ALU_src_b;
    logic               is_ecall;
    logic               illegal_inst;
    logic [STATE_W-1:0] state_out;

    modport master (
        input  part_of_inst,
        input  mem_ready,
        output PC_write_not_cond,
        output PC_write,
        output i_or_d,
        output mem_read,
        output mem_write,
        output IR_write,
        output reg_write,
        output mem_to_reg,
        output PC_source,
        output ALU_op,
        output ALU_src_a,
        output ALU_src_b,
        output is_ecall,
        output illegal_inst,
        output state_out
    );

    modport slave (
        output part_of_inst,
        output mem_ready,
        input  PC_write_not_cond,
        input  PC_write,
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        input  IR_write,
        input  reg_write,
        input  mem_to_reg,
        input  PC_source,
        input  ALU_op,
        input  ALU_src_a,
        input  ALU_src_b,
        input  is_ecall,
        input  illegal_inst,
        input  state_out
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: fetch/decode/execute/mem/wb,
// one state per cycle, with wait-state memory handshake and halt policy.
module multicycle_control_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit HALT_STICKY   = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_control_fsm_if.master bus
);

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_WB        = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JALR      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_ready;

    // Single-cycle memory builds tie the handshake high.
    assign w_ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH: begin
                w_next = w_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                unique case (bus.part_of_inst)
                    OP_LOAD,
                    OP_STORE:     w_next = S_MEM_ADDR;
                    OP_ARITH:     w_next = S_EXEC_R;
                    OP_ARITH_IMM: w_next = S_EXEC_I;
                    OP_BRANCH:    w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JUMP;
                    OP_JALR:      w_next = S_JALR;
                    OP_ECALL:     w_next = S_HALT;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                w_next = (bus.part_of_inst == OP_LOAD) ?
                         S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_next = w_ready ? S_WB : S_MEM_READ;
            end
            S_MEM_WRITE: begin
                w_next = w_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R,
            S_EXEC_I: begin
                w_next = S_ALU_WB;
            end
            S_HALT: begin
                w_next = HALT_STICKY ? S_HALT : S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_comb begin
        bus.PC_write_not_cond = 1'b0;
        bus.PC_write          = 1'b0;
        bus.i_or_d            = 1'b0;
        bus.mem_read          = 1'b0;
        bus.mem_write         = 1'b0;
        bus.IR_write          = 1'b0;
        bus.reg_write         = 1'b0;
        bus.mem_to_reg        = 2'b00;
        bus.PC_source         = 1'b0;
        bus.ALU_op            = 2'b00;
        bus.ALU_src_a         = 1'b0;
        bus.ALU_src_b         = 2'b00;
        bus.is_ecall          = 1'b0;
        bus.illegal_inst      = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                // IR and PC only latch on the cycle the fetch completes.
                bus.mem_read  = 1'b1;
                bus.ALU_src_b = 2'b01;
                bus.IR_write  = w_ready;
                bus.PC_write  = w_ready;
            end
            S_DECODE: begin
                bus.ALU_src_b = 2'b10;
                unique case (bus.part_of_inst)
                    OP_LOAD, OP_STORE, OP_ARITH, OP_ARITH_IMM,
                    OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: begin
                        bus.illegal_inst = 1'b0;
                    end
                    default: begin
                        bus.illegal_inst = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.ALU_src_a = 1'b1;
                bus.ALU_src_b = 2'b10;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                bus.ALU_src_a = 1'b1;
                bus.ALU_src_b = 2'b00;
                bus.ALU_op    = 2'b10;
            end
            S_EXEC_I: begin
                bus.ALU_src_a = 1'b1;
                bus.ALU_src_b = 2'b10;
                bus.ALU_op    = 2'b10;
            end
            S_ALU_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b00;
            end
            S_BRANCH: begin
                bus.ALU_src_a         = 1'b1;
                bus.ALU_src_b         = 2'b00;
                bus.ALU_op            = 2'b01;
                bus.PC_write_not_cond = 1'b1;
                bus.PC_source         = 1'b1;
            end
            S_JUMP: begin
                bus.PC_write   = 1'b1;
                bus.PC_source  = 1'b1;
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b10;
            end
            S_JALR: begin
                // Link value is the pre-update PC, already PC+4.
                bus.ALU_src_a  = 1'b1;
                bus.ALU_src_b  = 2'b10;
                bus.PC_write   = 1'b1;
                bus.PC_source  = 1'b0;
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b10;
            end
            S_HALT: begin
                bus.is_ecall = 1'b1;
            end
            default: begin
                bus.is_ecall = 1'b0;
            end
        endcase
    end

    assign bus.state_out = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle sequencer: a default instance and
// a single-cycle-memory, non-sticky-halt instance share the stimulus.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] AR  = 7'b0110011;
    localparam logic [6:0] AI  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] EC  = 7'b1110011;
    localparam logic [6:0] BAD = 7'b0000000;

    logic       clk;
    logic       rst;
    logic [6:0] opc;
    logic       rdy;
    int         n_cmp;
    int         n_bad;

    multicycle_control_fsm_if #(.STATE_W(4)) bus_a ();
    multicycle_control_fsm_if #(.STATE_W(4)) bus_b ();

    assign bus_a.part_of_inst = opc;
    assign bus_a.mem_ready    = rdy;
    assign bus_b.part_of_inst = opc;
    assign bus_b.mem_ready    = rdy;

    multicycle_control_fsm #(
        .MEM_HANDSHAKE(1'b1),
        .HALT_STICKY  (1'b1),
        .STATE_W      (4)
    ) u_dut_a (
        .clk  (clk),
        .reset(rst),
        .bus  (bus_a.master)
    );

    multicycle_control_fsm #(
        .MEM_HANDSHAKE(1'b0),
        .HALT_STICKY  (1'b0),
        .STATE_W      (4)
    ) u_dut_b (
        .clk  (clk),
        .reset(rst),
        .bus  (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, apply new inputs, then settle to the negedge.
    task automatic adv(input logic [6:0] op, input logic r);
        @(posedge clk);
        #1;
        opc = op;
        rdy = r;
        @(negedge clk);
    endtask

    // Reset edge, then land in the first FETCH cycle with the given inputs.
    task automatic rst_pulse(input logic [6:0] op, input logic r);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        opc = op;
        rdy = r;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        opc   = BAD;
        rdy   = 1'b0;
        @(negedge clk);

        // ARITH, no wait states: 0,1,6,8,0
        rst_pulse(AR, 1'b1);
        chk("rst_state", bus_a.state_out, 0);
        chk("rst_irw", bus_a.IR_write, 1);
        chk("rst_pcw", bus_a.PC_write, 1);
        chk("rst_memrd", bus_a.mem_read, 1);
        chk("rst_srcb", bus_a.ALU_src_b, 1);
        chk("rst_illegal", bus_a.illegal_inst, 0);
        adv(AR, 1'b1);
        chk("ar_dec", bus_a.state_out, 1);
        chk("ar_dec_srcb", bus_a.ALU_src_b, 2);
        chk("ar_dec_rw", bus_a.reg_write, 0);
        adv(AR, 1'b1);
        chk("ar_exec", bus_a.state_out, 6);
        chk("ar_exec_op", bus_a.ALU_op, 2);
        chk("ar_exec_srca", bus_a.ALU_src_a, 1);
        chk("ar_exec_rw", bus_a.reg_write, 0);
        adv(AR, 1'b1);
        chk("ar_wb", bus_a.state_out, 8);
        chk("ar_wb_rw", bus_a.reg_write, 1);
        chk("ar_wb_m2r", bus_a.mem_to_reg, 0);
        adv(AR, 1'b1);
        chk("ar_done", bus_a.state_out, 0);

        // LOAD: 2 waits in FETCH, 3 in MEM_READ -> 10 cycles
        rst_pulse(LD, 1'b0);
        chk("ld_f0", bus_a.state_out, 0);
        chk("ld_f0_irw", bus_a.IR_write, 0);
        chk("ld_f0_pcw", bus_a.PC_write, 0);
        adv(LD, 1'b0);
        chk("ld_f1", bus_a.state_out, 0);
        chk("ld_f1_irw", bus_a.IR_write, 0);
        adv(LD, 1'b1);
        chk("ld_f2", bus_a.state_out, 0);
        chk("ld_f2_irw", bus_a.IR_write, 1);
        adv(LD, 1'b0);
        chk("ld_dec", bus_a.state_out, 1);
        adv(LD, 1'b1);
        chk("ld_addr", bus_a.state_out, 2);
        chk("ld_addr_srcb", bus_a.ALU_src_b, 2);
        adv(LD, 1'b0);
        chk("ld_rd0", bus_a.state_out, 3);
        chk("ld_rd0_iod", bus_a.i_or_d, 1);
        adv(LD, 1'b0);
        chk("ld_rd1", bus_a.state_out, 3);
        adv(LD, 1'b0);
        chk("ld_rd2", bus_a.state_out, 3);
        chk("ld_rd2_mr", bus_a.mem_read, 1);
        adv(LD, 1'b1);
        chk("ld_rd3", bus_a.state_out, 3);
        adv(LD, 1'b0);
        chk("ld_wb", bus_a.state_out, 4);
        chk("ld_wb_m2r", bus_a.mem_to_reg, 1);
        chk("ld_wb_rw", bus_a.reg_write, 1);
        adv(LD, 1'b0);
        chk("ld_done", bus_a.state_out, 0);

        // JALR: 0,1,11
        rst_pulse(JR, 1'b1);
        adv(JR, 1'b1);
        chk("jr_dec", bus_a.state_out, 1);
        adv(JR, 1'b1);
        chk("jr_st", bus_a.state_out, 11);
        chk("jr_pcw", bus_a.PC_write, 1);
        chk("jr_pcs", bus_a.PC_source, 0);
        chk("jr_srcb", bus_a.ALU_src_b, 2);
        chk("jr_rw", bus_a.reg_write, 1);
        chk("jr_m2r", bus_a.mem_to_reg, 2);
        adv(JR, 1'b1);
        chk("jr_done", bus_a.state_out, 0);

        // ARITH_IMM, BRANCH, JAL
        rst_pulse(AI, 1'b1);
        adv(AI, 1'b1);
        adv(AI, 1'b1);
        chk("ai_exec", bus_a.state_out, 7);
        chk("ai_srcb", bus_a.ALU_src_b, 2);
        adv(AI, 1'b1);
        chk("ai_wb", bus_a.state_out, 8);
        rst_pulse(BR, 1'b1);
        adv(BR, 1'b1);
        adv(BR, 1'b1);
        chk("br_st", bus_a.state_out, 9);
        chk("br_pwnc", bus_a.PC_write_not_cond, 1);
        chk("br_op", bus_a.ALU_op, 1);
        chk("br_pcs", bus_a.PC_source, 1);
        adv(BR, 1'b1);
        chk("br_done", bus_a.state_out, 0);
        rst_pulse(JL, 1'b1);
        adv(JL, 1'b1);
        adv(JL, 1'b1);
        chk("jal_st", bus_a.state_out, 10);
        chk("jal_pcw", bus_a.PC_write, 1);
        chk("jal_m2r", bus_a.mem_to_reg, 2);
        adv(JL, 1'b1);
        chk("jal_done", bus_a.state_out, 0);

        // Illegal opcode
        rst_pulse(BAD, 1'b1);
        adv(BAD, 1'b1);
        chk("ill_dec", bus_a.state_out, 1);
        chk("ill_pulse", bus_a.illegal_inst, 1);
        chk("ill_rw", bus_a.reg_write, 0);
        chk("ill_mw", bus_a.mem_write, 0);
        adv(BAD, 1'b1);
        chk("ill_next", bus_a.state_out, 0);
        chk("ill_clear", bus_a.illegal_inst, 0);

        // Sticky ECALL
        rst_pulse(EC, 1'b1);
        adv(EC, 1'b1);
        adv(EC, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("halt_st", bus_a.state_out, 12);
            chk("halt_ecall", bus_a.is_ecall, 1);
            adv(EC, 1'b1);
        end
        rst_pulse(EC, 1'b1);
        chk("halt_rst", bus_a.state_out, 0);
        chk("halt_rst_ecall", bus_a.is_ecall, 0);

        // Reset while STORE waits in MEM_WRITE
        rst_pulse(ST, 1'b1);
        adv(ST, 1'b1);
        adv(ST, 1'b1);
        chk("st_addr", bus_a.state_out, 2);
        adv(ST, 1'b0);
        chk("st_mw", bus_a.state_out, 5);
        chk("st_mw_en", bus_a.mem_write, 1);
        adv(ST, 1'b0);
        chk("st_mw_wait", bus_a.state_out, 5);
        chk("st_mw_hold", bus_a.mem_write, 1);
        rst_pulse(ST, 1'b0);
        chk("st_rst", bus_a.state_out, 0);
        chk("st_rst_mw", bus_a.mem_write, 0);

        // Single-cycle memory, non-sticky halt instance
        rst_pulse(EC, 1'b0);
        chk("b_f_irw", bus_b.IR_write, 1);
        adv(EC, 1'b0);
        chk("b_dec", bus_b.state_out, 1);
        adv(EC, 1'b0);
        chk("b_halt", bus_b.state_out, 12);
        chk("b_ecall", bus_b.is_ecall, 1);
        adv(EC, 1'b0);
        chk("b_halt_exit", bus_b.state_out, 0);
        chk("b_ecall_clr", bus_b.is_ecall, 0);
        rst_pulse(ST, 1'b0);
        adv(ST, 1'b0);
        adv(ST, 1'b0);
        adv(ST, 1'b0);
        chk("b_st_mw", bus_b.state_out, 5);
        adv(ST, 1'b0);
        chk("b_st_done", bus_b.state_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
